fp_div: RTL and testbench
=========================

FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 7, stored fraction width (hidden 1 implied).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1: operand handshake.
REQ-006 SHALL have ports op1_sign input 1, op1_exp input EXP_WIDTH, op1_frac input FRAC_WIDTH: dividend.
REQ-007 SHALL have ports op2_sign input 1, op2_exp input EXP_WIDTH, op2_frac input FRAC_WIDTH: divisor.
REQ-008 SHALL have ports out_valid output 1 / out_ready input 1: result handshake.
REQ-009 SHALL have ports op3_sign output 1, op3_exp output EXP_WIDTH, op3_frac output FRAC_WIDTH: quotient.
REQ-010 SHALL have ports overflow, underflow, div_by_zero, each output 1: status flags, valid with out_valid.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-012 SHALL capture all operand fields on in_valid&&in_ready and go to CALC; later operand changes are ignored until the next accept.
REQ-013 SHALL perform restoring division of {1,op1_frac}<<(FRAC_WIDTH+1) by {1,op2_frac}, one quotient bit per CALC cycle, MSB first, giving q of FRAC_WIDTH+2 bits.
REQ-014 SHALL use an iteration counter; CALC lasts exactly FRAC_WIDTH+2 edges; out_valid rises after edge FRAC_WIDTH+2 counted from the accept edge, i.e. 9 cycles at defaults, for every operand class.
REQ-015 SHALL compute the signed exponent e = op1_exp - op2_exp + (2^(EXP_WIDTH-1)-1) in EXP_WIDTH+2 bits.
REQ-016 SHALL normalize: if q[FRAC_WIDTH+1]=1, op3_frac = q[FRAC_WIDTH:1] and exponent e; else op3_frac = q[FRAC_WIDTH-1:0] and exponent e-1; remainder discarded (truncation, no rounding).
REQ-017 SHALL set op3_sign = op1_sign ^ op2_sign in all cases.
REQ-018 SHALL treat an operand as zero iff exp==0 (subnormals flushed); exp all-ones inputs are treated as ordinary finite numbers.
REQ-019 SHALL, for divisor zero, output exp all-ones, frac 0, div_by_zero=1; this takes priority over a zero dividend.
REQ-020 SHALL, for dividend zero with divisor nonzero, output exp 0, frac 0, no flags.
REQ-021 SHALL, if normalized exponent > 2^EXP_WIDTH-2, output exp all-ones, frac 0, overflow=1.
REQ-022 SHALL, if normalized exponent < 1, output exp 0, frac 0, underflow=1.
REQ-023 SHALL register result and flags on entry to DONE and hold them stable while out_valid&&!out_ready.
REQ-024 SHALL return to IDLE on out_valid&&out_ready; in_ready is first high the cycle after; no accept occurs in the same cycle.
REQ-025 SHALL keep op3_*/flags unchanged in IDLE and CALC, holding the last result.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, counter 0, out_valid 0, in_ready 1, op3_sign/op3_exp/op3_frac 0 and all flags 0, asynchronously.
REQ-027 SHALL abort any division in progress on rst and discard it; no result is produced for that operation.
REQ-028 SHALL accept a new operand on the first rising edge after rst deasserts, if in_valid=1.

Verification
REQ-029 SHALL pass: 0x40C0 / 0x4000 (6.0/2.0) -> 0x4040, flags 0, out_valid exactly 9 cycles after accept.
REQ-030 SHALL pass: 0x3F80 / 0x3FC0 (1.0/1.5) -> 0x3F2A (truncated), flags 0.
REQ-031 SHALL pass: 0x7F00 / 0x0080 -> 0x7F80, overflow=1; 0x0080 / 0x7F00 -> 0x0000, underflow=1.
REQ-032 SHALL pass: 0xC000 / 0x0000 -> 0xFF80, div_by_zero=1; 0x0000 / 0x0000 -> 0x7F80, div_by_zero=1.
REQ-033 SHALL pass: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; in_ready rises the cycle after out_ready handshake.
REQ-034 SHALL pass: rst pulsed at CALC iteration 4 -> out_valid=0, outputs 0, in_ready=1 immediately; next operand completes with correct result and full 9-cycle latency.

Source files
------------

// File: rtl/fp_div.sv
// ---------------------------------------------------------------------------
// fp_div -- sequential floating-point divider (sign / biased exponent /
// fraction with hidden 1). Each division takes one quotient bit per cycle
// using restoring division. Subnormals are flushed to zero. The quotient
// fraction is truncated.
//
// Parameters
//   EXP_WIDTH   exponent field width
//   FRAC_WIDTH  stored fraction width (hidden 1 implied)
//
// Ports
//   clk                           rising-edge clock
//   rst                           asynchronous active-high reset
//   in_valid / in_ready           operand handshake (in_ready high in IDLE)
//   op1_sign/op1_exp/op1_frac     dividend
//   op2_sign/op2_exp/op2_frac     divisor
//   out_valid / out_ready         result handshake (out_valid high in DONE)
//   op3_sign/op3_exp/op3_frac     quotient, held until the next result
//   overflow/underflow/div_by_zero status flags, valid with out_valid
// ---------------------------------------------------------------------------
module fp_div #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op1_sign,
    input  logic [EXP_WIDTH-1:0]  op1_exp,
    input  logic [FRAC_WIDTH-1:0] op1_frac,
    input  logic                  op2_sign,
    input  logic [EXP_WIDTH-1:0]  op2_exp,
    input  logic [FRAC_WIDTH-1:0] op2_frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  op3_sign,
    output logic [EXP_WIDTH-1:0]  op3_exp,
    output logic [FRAC_WIDTH-1:0] op3_frac,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  div_by_zero
);

    // Quotient width: mantissa ratio lies in (0.5, 2), scaled by 2^(F+1).
    localparam int QW    = FRAC_WIDTH + 2;
    localparam int CNT_W = (QW > 1) ? $clog2(QW) : 1;
    // Signed exponent arithmetic needs two guard bits for the full range.
    localparam int SW    = EXP_WIDTH + 2;

    localparam logic signed [SW-1:0] BIAS  = SW'((2 ** (EXP_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] E_MAX = SW'((2 ** EXP_WIDTH) - 2);
    localparam logic signed [SW-1:0] ONE   = SW'(1);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(QW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [QW-1:0]         rem_q;       // partial remainder, always < 2*divisor
    logic [QW-2:0]         quo_q;       // quotient bits produced so far
    logic [FRAC_WIDTH:0]   mb_q;        // divisor mantissa with hidden 1
    logic [EXP_WIDTH-1:0]  exp1_q;
    logic [EXP_WIDTH-1:0]  exp2_q;
    logic                  sign_q;
    logic                  zero1_q;
    logic                  zero2_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  op3_sign_q;
    logic [EXP_WIDTH-1:0]  op3_exp_q;
    logic [FRAC_WIDTH-1:0] op3_frac_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  div_by_zero_q;

    // One restoring-division step: subtract the divisor if it fits,
    // record the quotient bit, then shift the remainder left.
    logic                  ge;
    logic [QW-1:0]         rem_sub;
    logic [QW-1:0]         rem_d;
    logic [QW-1:0]         quo_d;

    // Result that would be produced if this step were the last one.
    logic signed [SW-1:0]  e_raw;
    logic signed [SW-1:0]  e_norm;
    logic [EXP_WIDTH-1:0]  res_exp_d;
    logic [FRAC_WIDTH-1:0] res_frac_d;
    logic                  ovf_d;
    logic                  unf_d;
    logic                  dbz_d;

    always_comb begin
        ge      = (rem_q >= {1'b0, mb_q});
        rem_sub = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_d   = rem_sub << 1;
        quo_d   = {quo_q, ge};
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the if/else chain leaves it unassigned (latch).
        res_exp_d  = '0;
        res_frac_d = '0;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        dbz_d      = 1'b0;

        e_raw  = $signed({2'b00, exp1_q}) - $signed({2'b00, exp2_q}) + BIAS;
        // Quotient MSB clear means the mantissa ratio was below 1.
        e_norm = quo_d[QW-1] ? e_raw : (e_raw - ONE);

        if (zero2_q) begin
            // Division by zero wins even over a zero dividend.
            res_exp_d = '1;
            dbz_d     = 1'b1;
        end else if (zero1_q) begin
            res_exp_d = '0;
        end else if (e_norm > E_MAX) begin
            res_exp_d = '1;
            ovf_d     = 1'b1;
        end else if (e_norm < ONE) begin
            res_exp_d = '0;
            unf_d     = 1'b1;
        end else begin
            res_exp_d  = e_norm[EXP_WIDTH-1:0];
            res_frac_d = quo_d[QW-1] ? quo_d[FRAC_WIDTH:1] : quo_d[FRAC_WIDTH-1:0];
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            mb_q          <= '0;
            exp1_q        <= '0;
            exp2_q        <= '0;
            sign_q        <= 1'b0;
            zero1_q       <= 1'b0;
            zero2_q       <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            op3_sign_q    <= 1'b0;
            op3_exp_q     <= '0;
            op3_frac_q    <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                        cnt_q      <= '0;
                        // Dividend mantissa; the implied <<(F+1) is realised
                        // by shifting zeros into the remainder each step.
                        rem_q      <= {1'b0, 1'b1, op1_frac};
                        quo_q      <= '0;
                        mb_q       <= {1'b1, op2_frac};
                        exp1_q     <= op1_exp;
                        exp2_q     <= op2_exp;
                        sign_q     <= op1_sign ^ op2_sign;
                        zero1_q    <= (op1_exp == '0);
                        zero2_q    <= (op2_exp == '0);
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d[QW-2:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q       <= DONE;
                        out_valid_q   <= 1'b1;
                        op3_sign_q    <= sign_q;
                        op3_exp_q     <= res_exp_d;
                        op3_frac_q    <= res_frac_d;
                        overflow_q    <= ovf_d;
                        underflow_q   <= unf_d;
                        div_by_zero_q <= dbz_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign op3_sign    = op3_sign_q;
    assign op3_exp     = op3_exp_q;
    assign op3_frac    = op3_frac_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_fp_div.sv
// ---------------------------------------------------------------------------
// tb_fp_div -- self-checking bench for fp_div at default parameters
// (8-bit exponent, 7-bit fraction; operands written as 16-bit words
// {sign, exp, frac}). Directed cases plus randomized operands compared
// against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fp_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       op1_sign;
    logic [7:0] op1_exp;
    logic [6:0] op1_frac;
    logic       op2_sign;
    logic [7:0] op2_exp;
    logic [6:0] op2_frac;
    logic       out_valid;
    logic       out_ready;
    logic       op3_sign;
    logic [7:0] op3_exp;
    logic [6:0] op3_frac;
    logic       overflow;
    logic       underflow;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op1_sign    (op1_sign),
        .op1_exp     (op1_exp),
        .op1_frac    (op1_frac),
        .op2_sign    (op2_sign),
        .op2_exp     (op2_exp),
        .op2_frac    (op2_frac),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op3_sign    (op3_sign),
        .op3_exp     (op3_exp),
        .op3_frac    (op3_frac),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    // Reference: returns {overflow, underflow, div_by_zero, result[15:0]}.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
        int   ea, eb, ma, mb, q, e, frac;
        logic s;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ma = 128 + int'(a[6:0]);
        mb = 128 + int'(b[6:0]);
        s  = a[15] ^ b[15];
        if (eb == 0) return {3'b001, s, 8'hFF, 7'h00};
        if (ea == 0) return {3'b000, s, 15'h0000};
        q = (ma * 256) / mb;
        e = ea - eb + 127;
        if (q >= 256) begin
            frac = (q / 2) % 128;
        end else begin
            frac = q % 128;
            e    = e - 1;
        end
        if (e > 254) return {3'b100, s, 8'hFF, 7'h00};
        if (e < 1)   return {3'b010, s, 15'h0000};
        return {3'b000, s, e[7:0], frac[6:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [7:0] e;
        int         r;
        r = $urandom_range(0, 9);
        case (r)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 20));
            3:       e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(100, 155));
        endcase
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    function automatic logic [15:0] dut_res();
        return {op3_sign, op3_exp, op3_frac};
    endfunction

    function automatic logic [2:0] dut_flags();
        return {overflow, underflow, div_by_zero};
    endfunction

    task automatic drive_ops(input logic [15:0] a, input logic [15:0] b);
        {op1_sign, op1_exp, op1_frac} = a;
        {op2_sign, op2_exp, op2_frac} = b;
    endtask

    // Present operands until accepted; returns at accept edge + 1 with the
    // operand pins scrambled so late changes would corrupt a non-capturing DUT.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        drive_ops(a, b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drive_ops(16'($urandom), 16'($urandom));
    endtask

    // Number of edges after the accept edge until out_valid (50 = timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input int delay);
        repeat (delay) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_ops(16'h0, 16'h0);
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (dut_res() !== 16'h0000 || dut_flags() !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: res=%h flags=%b expected 0000/000", dut_res(), dut_flags());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] va [10];
        logic [15:0] vb [10];
        logic [15:0] vr [10];
        logic [2:0]  vf [10];
        int          lat;
        va[0] = 16'h40C0; vb[0] = 16'h4000; vr[0] = 16'h4040; vf[0] = 3'b000;
        va[1] = 16'h3F80; vb[1] = 16'h3FC0; vr[1] = 16'h3F2A; vf[1] = 3'b000;
        va[2] = 16'h7F00; vb[2] = 16'h0080; vr[2] = 16'h7F80; vf[2] = 3'b100;
        va[3] = 16'h0080; vb[3] = 16'h7F00; vr[3] = 16'h0000; vf[3] = 3'b010;
        va[4] = 16'hC000; vb[4] = 16'h0000; vr[4] = 16'hFF80; vf[4] = 3'b001;
        va[5] = 16'h0000; vb[5] = 16'h0000; vr[5] = 16'h7F80; vf[5] = 3'b001;
        va[6] = 16'h0000; vb[6] = 16'h4000; vr[6] = 16'h0000; vf[6] = 3'b000;
        va[7] = 16'h7F80; vb[7] = 16'h4000; vr[7] = 16'h7F00; vf[7] = 3'b000;
        va[8] = 16'h8000; vb[8] = 16'h4000; vr[8] = 16'h8000; vf[8] = 3'b000;
        va[9] = 16'h4000; vb[9] = 16'hC040; vr[9] = 16'hBF2A; vf[9] = 3'b000;
        for (int i = 0; i < 10; i++) begin
            start_op(va[i], vb[i]);
            wait_done(lat);
            checks++;
            if (lat != 9) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d cycles expected 9", i, lat);
            end
            checks++;
            if (dut_res() !== vr[i] || dut_flags() !== vf[i]) begin
                failures++;
                $display("FAIL directed[%0d] %h/%h: got %h flags %b expected %h flags %b",
                         i, va[i], vb[i], dut_res(), dut_flags(), vr[i], vf[i]);
            end
            release_result(0);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'h3F80, 16'h3FC0);
        wait_done(lat);
        release_result(0);
        start_op(16'h40C0, 16'h4000);
        // In CALC: previous result still held, no operand accepted.
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dut_res() !== 16'h3F2A) begin
            failures++;
            $display("FAIL calc_hold: in_ready=%b out_valid=%b res=%h expected 0/0/3f2a",
                     in_ready, out_valid, dut_res());
        end
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_res() !== 16'h4040 || dut_flags() !== 3'b000) begin
                failures++;
                $display("FAIL stall[%0d]: out_valid=%b in_ready=%b res=%h flags=%b expected 1/0/4040/000",
                         i, out_valid, in_ready, dut_res(), dut_flags());
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_res() !== 16'h4040) begin
            failures++;
            $display("FAIL after_handshake: out_valid=%b in_ready=%b res=%h expected 0/1/4040",
                     out_valid, in_ready, dut_res());
        end
    endtask

    task automatic test_reset_abort();
        int          lat;
        logic [18:0] exp_v;
        start_op(16'hC0C0, 16'h3FA0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_res() !== 16'h0000 || dut_flags() !== 3'b000) begin
            failures++;
            $display("FAIL abort_async: out_valid=%b in_ready=%b res=%h flags=%b expected 0/1/0000/000",
                     out_valid, in_ready, dut_res(), dut_flags());
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        drive_ops(16'h4100, 16'h3FC0);
        exp_v = model(16'h4100, 16'h3FC0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drive_ops(16'($urandom), 16'($urandom));
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_accept: in_ready=%b expected 0", in_ready);
        end
        wait_done(lat);
        checks++;
        if (lat != 9) begin
            failures++;
            $display("FAIL post_reset_latency: got %0d cycles expected 9", lat);
        end
        checks++;
        if (dut_res() !== exp_v[15:0] || dut_flags() !== exp_v[18:16]) begin
            failures++;
            $display("FAIL post_reset_result: got %h flags %b expected %h flags %b",
                     dut_res(), dut_flags(), exp_v[15:0], exp_v[18:16]);
        end
        release_result(0);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [18:0] exp_v;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            a     = rand_op();
            b     = rand_op();
            exp_v = model(a, b);
            start_op(a, b);
            wait_done(lat);
            checks++;
            if (lat != 9) begin
                failures++;
                $display("FAIL random_latency[%0d]: got %0d cycles expected 9", i, lat);
            end
            checks++;
            if (dut_res() !== exp_v[15:0] || dut_flags() !== exp_v[18:16]) begin
                failures++;
                $display("FAIL random[%0d] %h/%h: got %h flags %b expected %h flags %b",
                         i, a, b, dut_res(), dut_flags(), exp_v[15:0], exp_v[18:16]);
            end
            release_result($urandom_range(0, 2));
        end
    endtask

    // in_valid and out_ready held high: accept at edge 0, result at edge 9,
    // return to IDLE at 10, next accept at 11, second result at 20.
    task automatic test_back_to_back();
        logic [15:0] a0, b0, a1, b1;
        logic [18:0] e0, e1;
        a0 = rand_op(); b0 = {1'($urandom), 8'($urandom_range(100, 155)), 7'($urandom)};
        a1 = rand_op(); b1 = {1'($urandom), 8'($urandom_range(100, 155)), 7'($urandom)};
        e0 = model(a0, b0);
        e1 = model(a1, b1);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive_ops(a0, b0);
        @(posedge clk);
        #1;
        drive_ops(a1, b1);
        for (int n = 1; n <= 21; n++) begin
            @(posedge clk);
            #1;
            if (n == 11) in_valid = 1'b0;
            checks++;
            if (out_valid !== ((n == 9) || (n == 20))) begin
                failures++;
                $display("FAIL b2b_valid edge %0d: out_valid=%b", n, out_valid);
            end
            if (n == 9) begin
                checks++;
                if (dut_res() !== e0[15:0] || dut_flags() !== e0[18:16]) begin
                    failures++;
                    $display("FAIL b2b_first %h/%h: got %h flags %b expected %h flags %b",
                             a0, b0, dut_res(), dut_flags(), e0[15:0], e0[18:16]);
                end
            end
            if (n == 10) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready edge 10: in_ready=%b expected 1", in_ready);
                end
            end
            if (n == 20) begin
                checks++;
                if (dut_res() !== e1[15:0] || dut_flags() !== e1[18:16]) begin
                    failures++;
                    $display("FAIL b2b_second %h/%h: got %h flags %b expected %h flags %b",
                             a1, b1, dut_res(), dut_flags(), e1[15:0], e1[18:16]);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
